plic_core_mt: RTL and testbench

//  Multi-target PLIC core: NUM_SRC sources gated (level/edge), arbitrated per target (hart context).

---
 rtl/plic_pkg.sv | 24 ++
 rtl/plic_tgt_arb.sv | 67 ++++++
 rtl/plic_core_mt.sv | 164 ++++++++++++++++
 tb/tb_plic_core_mt.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared types and width helpers for the multi-target PLIC core.
package plic_pkg;

  typedef enum logic [1:0] {
    GwIdle  = 2'd0,
    GwPend  = 2'd1,
    GwInsvc = 2'd2
  } gw_state_e;

  function automatic int unsigned id_width(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

  localparam int unsigned DefPrioW = 3;
  localparam int unsigned DefIdW   = 5;

  typedef logic [DefPrioW-1:0] prio_t;
  typedef logic [DefIdW-1:0]   id_t;

endpackage

// File: rtl/plic_tgt_arb.sv
// Per-target arbiter: registered masked priorities, max-tree, registered winner and irq.
module plic_tgt_arb #(
  parameter int unsigned NUM_SRC = 31,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_SRC-1:0]             ip_i,
  input  logic [NUM_SRC-1:0]             ie_i,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]              thold_i,
  output logic [ID_W-1:0]                best_id_o,
  output logic [PRIO_W-1:0]              best_prio_o,
  output logic                           irq_o
);

  logic [NUM_SRC-1:0][PRIO_W-1:0] r_mprio;
  logic [ID_W-1:0]                w_max_id;
  logic [PRIO_W-1:0]              w_max_prio;
  logic [ID_W-1:0]                r_best_id;
  logic [PRIO_W-1:0]              r_best_prio;
  logic                           r_irq;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mprio <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        r_mprio[s] <= (ip_i[s] && ie_i[s]) ? prio_i[s] : '0;
      end
    end
  end

  // Strict '>' keeps the lowest id on ties; priority 0 can never win.
  always_comb begin
    logic [PRIO_W-1:0] max_prio;
    logic [ID_W-1:0]   max_id;
    max_prio = '0;
    max_id   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (r_mprio[s] > max_prio) begin
        max_prio = r_mprio[s];
        max_id   = ID_W'(s + 1);
      end
    end
    w_max_prio = max_prio;
    w_max_id   = max_id;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_best_id   <= '0;
      r_best_prio <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_best_id   <= w_max_id;
      r_best_prio <= w_max_prio;
      r_irq       <= (w_max_prio > thold_i);
    end
  end

  assign best_id_o   = r_best_id;
  assign best_prio_o = r_best_prio;
  assign irq_o       = r_irq;

endmodule

// File: rtl/plic_core_mt.sv
// Multi-target PLIC core: per-source level/edge gateways, claim/complete resolution
// and one two-stage arbiter per target.
module plic_core_mt
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 31,
  parameter int unsigned NUM_TGT  = 2,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned MAX_PEND = 8,
  localparam int unsigned ID_W    = id_width(NUM_SRC)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_SRC-1:0]              irq_i,
  input  logic [NUM_SRC-1:0]              tm_i,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0]  prio_i,
  input  logic [NUM_TGT-1:0][NUM_SRC-1:0] ie_i,
  input  logic [NUM_TGT-1:0][PRIO_W-1:0]  thold_i,
  input  logic [NUM_TGT-1:0]              claim_i,
  input  logic [NUM_TGT-1:0]              comp_i,
  input  logic [NUM_TGT-1:0][ID_W-1:0]    comp_id_i,
  output logic [NUM_TGT-1:0][ID_W-1:0]    claim_id_o,
  output logic [NUM_SRC-1:0]              ip_o,
  output logic [NUM_TGT-1:0]              irq_o
);

  localparam int unsigned CNT_W = cnt_width(MAX_PEND);
  localparam int unsigned TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  gw_state_e          r_state     [NUM_SRC];
  logic [CNT_W-1:0]   r_cnt       [NUM_SRC];
  logic [TGT_W-1:0]   r_owner     [NUM_SRC];
  logic [NUM_SRC-1:0] r_irq_prev;

  gw_state_e          w_st_pc     [NUM_SRC];
  gw_state_e          w_state_d   [NUM_SRC];
  logic [CNT_W-1:0]   w_cnt_d     [NUM_SRC];
  logic [TGT_W-1:0]   w_claim_tgt [NUM_SRC];
  logic [NUM_SRC-1:0] w_comp_ok;
  logic [NUM_SRC-1:0] w_claimed;

  logic [NUM_TGT-1:0][ID_W-1:0]   w_best_id;
  logic [NUM_TGT-1:0][PRIO_W-1:0] w_best_prio;
  logic [NUM_TGT-1:0][ID_W-1:0]   w_claim_id;

  for (genvar t = 0; t < NUM_TGT; t++) begin : g_tgt
    plic_tgt_arb #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W),
      .ID_W    (ID_W)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ip_i        (ip_o),
      .ie_i        (ie_i[t]),
      .prio_i      (prio_i),
      .thold_i     (thold_i[t]),
      .best_id_o   (w_best_id[t]),
      .best_prio_o (w_best_prio[t]),
      .irq_o       (irq_o[t])
    );
  end

  // Complete is honoured only from the target that owns the in-service source.
  always_comb begin
    w_comp_ok = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (comp_i[t] && comp_id_i[t] == ID_W'(s + 1) && r_state[s] == GwInsvc &&
            r_owner[s] == TGT_W'(t)) begin
          w_comp_ok[s] = 1'b1;
        end
      end
    end
  end

  // Gateway state as seen after this cycle's complete, so claim observes it.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      w_st_pc[s] = r_state[s];
      if (w_comp_ok[s]) begin
        w_st_pc[s] = (tm_i[s] && r_cnt[s] != '0) ? GwPend : GwIdle;
      end
    end
  end

  // Targets are visited in index order, so the lowest index takes a contested id.
  always_comb begin
    logic [NUM_SRC-1:0] taken;
    taken      = '0;
    w_claim_id = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_claim_tgt[s] = '0;
    end
    for (int t = 0; t < NUM_TGT; t++) begin
      if (claim_i[t] && w_best_prio[t] > thold_i[t]) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (w_best_id[t] == ID_W'(s + 1) && w_st_pc[s] == GwPend && !taken[s]) begin
            taken[s]       = 1'b1;
            w_claim_tgt[s] = TGT_W'(t);
            w_claim_id[t]  = w_best_id[t];
          end
        end
      end
    end
    w_claimed = taken;
  end

  always_comb begin
    logic [CNT_W-1:0] cnt;
    for (int s = 0; s < NUM_SRC; s++) begin
      cnt          = '0;
      w_state_d[s] = w_st_pc[s];
      if (tm_i[s]) begin
        cnt = r_cnt[s] - CNT_W'(w_claimed[s]);
        if (irq_i[s] && !r_irq_prev[s] && cnt != CNT_W'(MAX_PEND)) begin
          cnt = cnt + CNT_W'(1);
        end
        if (w_claimed[s]) begin
          w_state_d[s] = GwInsvc;
        end else if (w_st_pc[s] != GwInsvc) begin
          w_state_d[s] = (cnt != '0) ? GwPend : GwIdle;
        end
      end else begin
        // A level source just completed waits one cycle before re-pending.
        if (w_claimed[s]) begin
          w_state_d[s] = GwInsvc;
        end else if (w_st_pc[s] == GwIdle && irq_i[s] && !w_comp_ok[s]) begin
          w_state_d[s] = GwPend;
        end
      end
      w_cnt_d[s] = cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_prev <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        r_state[s] <= GwIdle;
        r_cnt[s]   <= '0;
        r_owner[s] <= '0;
      end
    end else begin
      r_irq_prev <= irq_i;
      for (int s = 0; s < NUM_SRC; s++) begin
        r_state[s] <= w_state_d[s];
        r_cnt[s]   <= w_cnt_d[s];
        if (w_claimed[s]) begin
          r_owner[s] <= w_claim_tgt[s];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      ip_o[s] = (r_state[s] == GwPend);
    end
  end

  assign claim_id_o = w_claim_id;

endmodule

// File: tb/tb_plic_core_mt.sv
// Bench for plic_core_mt: directed table, corner sequences and a random run against a model.
module tb_plic_core_mt;

  localparam int NS = 31;
  localparam int NT = 2;
  localparam int PW = 3;
  localparam int MP = 8;
  localparam int IW = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NS-1:0]            irq;
  logic [NS-1:0]            tm;
  logic [NS-1:0][PW-1:0]    prio;
  logic [NT-1:0][NS-1:0]    ie;
  logic [NT-1:0][PW-1:0]    thold;
  logic [NT-1:0]            claim;
  logic [NT-1:0]            comp;
  logic [NT-1:0][IW-1:0]    comp_id;
  logic [NT-1:0][IW-1:0]    claim_id;
  logic [NS-1:0]            ip;
  logic [NT-1:0]            irq_out;

  always #5 clk = ~clk;

  plic_core_mt #(
    .NUM_SRC  (NS),
    .NUM_TGT  (NT),
    .PRIO_W   (PW),
    .MAX_PEND (MP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .tm_i       (tm),
    .prio_i     (prio),
    .ie_i       (ie),
    .thold_i    (thold),
    .claim_i    (claim),
    .comp_i     (comp),
    .comp_id_i  (comp_id),
    .claim_id_o (claim_id),
    .ip_o       (ip),
    .irq_o      (irq_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pending / in-service flags, edge counts, owners, and the
  // arbitration pipeline as two delayed snapshots.
  bit m_pend  [NS];
  bit m_busy  [NS];
  int m_cnt   [NS];
  int m_owner [NS];
  bit m_prev  [NS];
  int m_s1    [NT][NS];
  int m_bid   [NT];
  int m_bprio [NT];
  bit m_irq   [NT];
  bit e_done  [NS];
  bit e_pcp   [NS];
  int e_grant [NS];
  int e_claim [NT];
  int last_claim [NT];

  typedef struct {
    int            sa;
    int            pa;
    int            sb;
    int            pb;
    logic [NS-1:0] iem;
    int            th;
    int            eirq;
    int            eid;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = 0; m_busy[s] = 0; m_cnt[s] = 0; m_owner[s] = 0; m_prev[s] = 0;
    end
    for (int t = 0; t < NT; t++) begin
      m_bid[t] = 0; m_bprio[t] = 0; m_irq[t] = 0;
      for (int s = 0; s < NS; s++) m_s1[t][s] = 0;
    end
  endfunction

  function automatic void model_eval();
    for (int s = 0; s < NS; s++) begin
      e_done[s]  = 0;
      e_grant[s] = -1;
    end
    for (int t = 0; t < NT; t++) begin
      int id;
      id = int'(comp_id[t]);
      if (comp[t] && id >= 1 && id <= NS) begin
        if (m_busy[id-1] && m_owner[id-1] == t) e_done[id-1] = 1;
      end
    end
    for (int s = 0; s < NS; s++) e_pcp[s] = m_pend[s] || (e_done[s] && tm[s] && m_cnt[s] > 0);
    for (int t = 0; t < NT; t++) begin
      e_claim[t] = 0;
      if (claim[t] && m_bid[t] != 0 && m_bprio[t] > int'(thold[t])) begin
        if (e_pcp[m_bid[t]-1] && e_grant[m_bid[t]-1] < 0) begin
          e_grant[m_bid[t]-1] = t;
          e_claim[t] = m_bid[t];
        end
      end
    end
  endfunction

  function automatic void model_commit();
    for (int t = 0; t < NT; t++) begin
      int best, bid;
      best = 0; bid = 0;
      for (int s = 0; s < NS; s++) begin
        if (m_s1[t][s] > best) begin best = m_s1[t][s]; bid = s + 1; end
      end
      m_bid[t] = bid; m_bprio[t] = best; m_irq[t] = (best > int'(thold[t]));
      for (int s = 0; s < NS; s++) m_s1[t][s] = (m_pend[s] && ie[t][s]) ? int'(prio[s]) : 0;
    end
    for (int s = 0; s < NS; s++) begin
      bit rise, g;
      rise = irq[s] && !m_prev[s];
      g = (e_grant[s] >= 0);
      if (tm[s]) begin
        m_cnt[s] = m_cnt[s] - (g ? 1 : 0);
        if (rise && m_cnt[s] < MP) m_cnt[s]++;
      end else begin
        m_cnt[s] = 0;
      end
      if (g) begin
        m_busy[s] = 1; m_pend[s] = 0; m_owner[s] = e_grant[s];
      end else if (m_busy[s] && !e_done[s]) begin
        m_busy[s] = 1;
      end else begin
        m_busy[s] = 0;
        m_pend[s] = tm[s] ? (m_cnt[s] > 0) : (e_pcp[s] || (irq[s] && !e_done[s]));
      end
      m_prev[s] = irq[s];
    end
  endfunction

  // Inputs are set just after a negedge; compare 1 time unit later, then let the edge pass.
  task automatic tick();
    logic [NS-1:0] eip;
    logic [NT-1:0] eirq;
    #1;
    if (rst) model_reset();
    model_eval();
    for (int s = 0; s < NS; s++) eip[s] = m_pend[s];
    for (int t = 0; t < NT; t++) eirq[t] = m_irq[t];
    chk("ip_o", int'(ip), int'(eip));
    chk("irq_o", int'(irq_out), int'(eirq));
    for (int t = 0; t < NT; t++) begin
      last_claim[t] = int'(claim_id[t]);
      chk($sformatf("claim_id_o[%0d]", t), last_claim[t], e_claim[t]);
    end
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    irq = '0; tm = '0; prio = '0; ie = '0; thold = '0;
    claim = '0; comp = '0; comp_id = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic claim_one(input int t);
    claim[t] = 1'b1;
    tick();
    claim[t] = 1'b0;
  endtask

  task automatic complete_one(input int t, input int id);
    comp[t] = 1'b1;
    comp_id[t] = IW'(id);
    tick();
    comp[t] = 1'b0;
    comp_id[t] = '0;
  endtask

  initial begin
    tbl[0] = '{5, 3, 0, 0, 31'h7FFF_FFFF, 0, 1, 5};
    tbl[1] = '{2, 4, 7, 4, 31'h7FFF_FFFF, 0, 1, 2};
    tbl[2] = '{3, 4, 0, 0, 31'h7FFF_FFFF, 4, 0, 0};
    tbl[3] = '{3, 4, 0, 0, 31'h7FFF_FFFF, 3, 1, 3};
    tbl[4] = '{1, 6, 31, 7, 31'h7FFF_FFFF, 2, 1, 31};
    tbl[5] = '{9, 0, 10, 1, 31'h7FFF_FFFF, 0, 1, 10};
    tbl[6] = '{12, 5, 13, 5, 31'h0000_1000, 1, 1, 13};
    tbl[7] = '{20, 2, 21, 2, 31'h0000_0000, 0, 0, 0};

    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset ip_o", int'(ip), 0);
    chk("reset irq_o", int'(irq_out), 0);
    chk("reset claim_id_o", int'(claim_id), 0);

    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      do_reset();
      if (tbl[i].sa != 0) begin prio[tbl[i].sa-1] = PW'(tbl[i].pa); irq[tbl[i].sa-1] = 1'b1; end
      if (tbl[i].sb != 0) begin prio[tbl[i].sb-1] = PW'(tbl[i].pb); irq[tbl[i].sb-1] = 1'b1; end
      ie[0] = tbl[i].iem;
      thold[0] = PW'(tbl[i].th);
      wait_n(3);
      chk($sformatf("tbl%0d irq", i), int'(irq_out[0]), tbl[i].eirq);
      claim_one(0);
      chk($sformatf("tbl%0d claim", i), last_claim[0], tbl[i].eid);
    end

    // Level source 5: latency, claim, complete.
    clear_inputs(); do_reset();
    prio[4] = 3'd3; ie[0][4] = 1'b1; irq[4] = 1'b1;
    wait_n(2);
    chk("lvl irq before 3", int'(irq_out[0]), 0);
    tick();
    chk("lvl irq at 3", int'(irq_out[0]), 1);
    claim_one(0);
    chk("lvl claim", last_claim[0], 5);
    chk("lvl ip cleared", int'(ip[4]), 0);
    irq[4] = 1'b0;
    complete_one(0, 5);
    wait_n(2);
    chk("lvl irq dropped", int'(irq_out[0]), 0);

    // Equal priorities: lowest id first.
    clear_inputs(); do_reset();
    prio[1] = 3'd4; prio[6] = 3'd4; ie[0] = '1; irq[1] = 1'b1; irq[6] = 1'b1;
    wait_n(3);
    claim_one(0);
    chk("tie first", last_claim[0], 2);
    wait_n(3);
    claim_one(0);
    chk("tie second", last_claim[0], 7);

    // Contested claim and a complete from the non-owner.
    clear_inputs(); do_reset();
    prio[2] = 3'd2; ie[0][2] = 1'b1; ie[1][2] = 1'b1; irq[2] = 1'b1;
    wait_n(3);
    claim = 2'b11;
    tick();
    claim = 2'b00;
    chk("race tgt0", last_claim[0], 3);
    chk("race tgt1", last_claim[1], 0);
    complete_one(1, 3);
    tick();
    chk("foreign complete ignored", int'(ip[2]), 0);
    complete_one(0, 3);
    chk("owner complete idle", int'(ip[2]), 0);
    tick();
    chk("owner complete re-pend", int'(ip[2]), 1);

    // Edge source 1: 10 pulses saturate at 8.
    clear_inputs();
    tm[0] = 1'b1;
    do_reset();
    prio[0] = 3'd1; ie[0][0] = 1'b1;
    for (int p = 0; p < 10; p++) begin
      irq[0] = 1'b1; tick();
      irq[0] = 1'b0; tick();
    end
    wait_n(2);
    for (int k = 0; k < MP; k++) begin
      claim_one(0);
      chk($sformatf("edge claim %0d", k), last_claim[0], 1);
      complete_one(0, 1);
      wait_n(3);
    end
    claim_one(0);
    chk("edge claim after drain", last_claim[0], 0);
    chk("edge ip after drain", int'(ip[0]), 0);

    // Reset while in service with the level request held.
    clear_inputs(); do_reset();
    prio[4] = 3'd3; ie[0][4] = 1'b1; irq[4] = 1'b1;
    wait_n(3);
    claim_one(0);
    chk("rst pre claim", last_claim[0], 5);
    tick();
    chk("rst pre ip", int'(ip[4]), 0);
    do_reset();
    tick();
    chk("rst re-pend", int'(ip[4]), 1);
    wait_n(2);
    claim_one(0);
    chk("rst reclaim", last_claim[0], 5);

    // Random episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      clear_inputs();
      tm = NS'($urandom);
      do_reset();
      for (int s = 0; s < NS; s++) prio[s] = PW'($urandom);
      for (int t = 0; t < NT; t++) begin
        ie[t] = NS'($urandom);
        thold[t] = PW'($urandom_range(0, 3));
      end
      for (int c = 0; c < 500; c++) begin
        int cand[$];
        irq = irq ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
        if ($urandom_range(0, 15) == 0) prio[$urandom_range(0, NS-1)] = PW'($urandom);
        if ($urandom_range(0, 31) == 0) thold[$urandom_range(0, NT-1)] = PW'($urandom_range(0, 4));
        for (int t = 0; t < NT; t++) begin
          claim[t] = ($urandom_range(0, 2) == 0);
          comp[t] = ($urandom_range(0, 3) == 0);
          cand.delete();
          for (int s = 0; s < NS; s++) if (m_busy[s] && m_owner[s] == t) cand.push_back(s + 1);
          if (cand.size() > 0 && $urandom_range(0, 1) == 1)
            comp_id[t] = IW'(cand[$urandom_range(0, cand.size()-1)]);
          else
            comp_id[t] = IW'($urandom_range(0, NS));
        end
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
